// File: rtl/fc_mac_engine.sv
// Fully-connected layer MAC engine: LANES output neurons per group, one input per cycle.
// Build option: define FC_MAC_ENGINE_RELU_EN to clamp negative results to zero (ReLU).
module fc_mac_engine #(
    parameter              NAME        = "FC_MAC_ENGINE",
    parameter int unsigned NUM_INPUTS  = 16,
    parameter int unsigned NUM_OUTPUTS = 10,
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned ACC_W       = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_act,
    input  logic              wr_weight,
    input  logic              wr_bias,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [15:0]       wr_in_idx,
    input  logic [15:0]       wr_out_idx,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [15:0]       rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned IN_IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OUT_IW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int unsigned GROUPS = (NUM_OUTPUTS + LANES - 1) / LANES;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned PW     = 2 * DATA_W;

    localparam logic [IN_IW-1:0] K_LAST = IN_IW'(NUM_INPUTS - 1);
    localparam logic [GW-1:0]    G_LAST = GW'(GROUPS - 1);

    if (NUM_INPUTS < 1 || NUM_OUTPUTS < 1 || LANES < 1 || LANES > NUM_OUTPUTS ||
        FRAC_BITS >= DATA_W || ACC_W < PW + $clog2(NUM_INPUTS)) begin : g_param_check
        $error("%s: illegal parameter combination", NAME);
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     g_q, g_d;
    logic [IN_IW-1:0]  k_q, k_d;
    logic              acc_clr;

    logic signed [DATA_W-1:0] act_mem    [NUM_INPUTS];
    logic signed [DATA_W-1:0] weight_mem [NUM_OUTPUTS][NUM_INPUTS];
    logic signed [DATA_W-1:0] bias_mem   [NUM_OUTPUTS];
    logic signed [DATA_W-1:0] out_mem    [NUM_OUTPUTS];

    logic signed [ACC_W-1:0]  acc        [LANES];
    logic                     lane_vld   [LANES];
    logic [OUT_IW-1:0]        lane_idx   [LANES];
    logic signed [ACC_W-1:0]  lane_prod  [LANES];
    logic signed [DATA_W-1:0] lane_res   [LANES];

    logic              in_ok, out_ok, wr_open;
    logic [IN_IW-1:0]  in_sel;
    logic [OUT_IW-1:0] out_sel, rd_sel;

    // Full 16-bit indices are range-checked before truncation so aliases never commit.
    assign in_ok   = (32'(wr_in_idx) < 32'(NUM_INPUTS));
    assign out_ok  = (32'(wr_out_idx) < 32'(NUM_OUTPUTS));
    assign in_sel  = IN_IW'(wr_in_idx);
    assign out_sel = OUT_IW'(wr_out_idx);
    assign wr_open = !busy;

    // Per-lane datapath: product for the MAC step, rounding/saturation for FINISH.
    for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
        logic [31:0]              o;
        logic signed [PW-1:0]     p;
        logic signed [ACC_W:0]    sum;
        logic signed [ACC_W:0]    shifted;
        logic signed [DATA_W-1:0] trunc;
        logic signed [DATA_W-1:0] sat;

        assign o            = 32'(g_q) * 32'(LANES) + 32'(j);
        assign lane_vld[j]  = (o < 32'(NUM_OUTPUTS));
        assign lane_idx[j]  = lane_vld[j] ? OUT_IW'(o) : '0;

        assign p            = PW'(act_mem[k_q]) * PW'(weight_mem[lane_idx[j]][k_q]);
        assign lane_prod[j] = lane_vld[j] ? ACC_W'(p) : '0;

        assign sum     = (ACC_W+1)'(acc[j]) + ((ACC_W+1)'(bias_mem[lane_idx[j]]) <<< FRAC_BITS);
        assign shifted = sum >>> FRAC_BITS;
        assign trunc   = DATA_W'(shifted);
        // In range iff sign-extending the truncated value reproduces the wide one.
        assign sat     = (shifted == (ACC_W+1)'(trunc)) ? trunc :
                         (shifted[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}});
`ifdef FC_MAC_ENGINE_RELU_EN
        assign lane_res[j] = sat[DATA_W-1] ? '0 : sat;
`else
        assign lane_res[j] = sat;
`endif
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin : ctrl_regs
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            k_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            k_q     <= k_d;
            busy    <= (state_d == MAC) || (state_d == FINISH);
            done    <= (state_q == DONE);
        end
    end

    always_comb begin : ctrl_next
        state_d = state_q;
        g_d     = g_q;
        k_d     = k_q;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    g_d     = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
                end
            end
            MAC: begin
                k_d = k_q + IN_IW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (g_q == G_LAST) begin
                    state_d = DONE;
                end else begin
                    g_d     = g_q + GW'(1);
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = MAC;
                end
            end
            DONE: begin
                state_d = IDLE;
                g_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : acc_regs
        for (int j = 0; j < int'(LANES); j++) begin
            if (!rst_n || acc_clr) begin
                acc[j] <= '0;
            end else if (state_q == MAC) begin
                acc[j] <= acc[j] + lane_prod[j];
            end
        end
    end

    // Storage is deliberately not reset; results commit only in a FINISH cycle outside reset.
    always_ff @(posedge clk) begin : mem_write
        if (wr_open && in_ok && wr_act) begin
            act_mem[in_sel] <= wr_data;
        end
        if (wr_open && in_ok && out_ok && wr_weight) begin
            weight_mem[out_sel][in_sel] <= wr_data;
        end
        if (wr_open && out_ok && wr_bias) begin
            bias_mem[out_sel] <= wr_data;
        end
        if (rst_n && state_q == FINISH) begin
            for (int j = 0; j < int'(LANES); j++) begin
                if (lane_vld[j]) begin
                    out_mem[lane_idx[j]] <= lane_res[j];
                end
            end
        end
    end

    assign rd_sel  = OUT_IW'(rd_idx);
    assign rd_data = (32'(rd_idx) < 32'(NUM_OUTPUTS)) ? out_mem[rd_sel] : '0;

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed self-checking bench for fc_mac_engine (4 inputs, 3 outputs, 2 lanes, Q8.8).
module tb_fc_mac_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_act, wr_weight, wr_bias;
    logic [15:0] wr_data, wr_in_idx, wr_out_idx;
    logic        start;
    logic        busy, done;
    logic [15:0] rd_idx;
    logic [15:0] rd_data;

    int tests = 0;
    int fails = 0;

`ifdef FC_MAC_ENGINE_RELU_EN
    localparam logic [15:0] EXP_NEG     = 16'h0000;
    localparam logic [15:0] EXP_NEG_SAT = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG     = 16'hFC00;
    localparam logic [15:0] EXP_NEG_SAT = 16'h8000;
`endif

    fc_mac_engine #(
        .NAME("FC_MAC_ENGINE"), .NUM_INPUTS(4), .NUM_OUTPUTS(3), .LANES(2),
        .DATA_W(16), .FRAC_BITS(8), .ACC_W(40)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_act(wr_act), .wr_weight(wr_weight), .wr_bias(wr_bias), .wr_data(wr_data),
        .wr_in_idx(wr_in_idx), .wr_out_idx(wr_out_idx),
        .start(start), .busy(busy), .done(done),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // One write cycle; inputs change 1 time unit after the edge.
    task automatic wr(input logic a, input logic w, input logic b,
                      input int in_i, input int out_i, input logic [15:0] d);
        wr_act = a; wr_weight = w; wr_bias = b;
        wr_in_idx = 16'(in_i); wr_out_idx = 16'(out_i); wr_data = d;
        @(posedge clk); #1;
        wr_act = 1'b0; wr_weight = 1'b0; wr_bias = 1'b0;
    endtask

    task automatic load_uniform(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 4; k++) wr(1'b1, 1'b0, 1'b0, k, 0, a);
        for (int o = 0; o < 3; o++)
            for (int k = 0; k < 4; k++) wr(1'b0, 1'b1, 1'b0, k, o, w);
        for (int o = 0; o < 3; o++) wr(1'b0, 1'b0, 1'b1, 0, o, b);
    endtask

    // Launch a job and measure edges from the start-sampling edge to done; -1 on timeout.
    task automatic run_job(output int lat, output logic busy_start,
                           output logic busy_done, output logic done_after);
        int c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_start = busy;
        busy_done  = 1'b1;
        lat = -1;
        c = 0;
        while (c < 60 && lat < 0) begin
            @(posedge clk); #1;
            c++;
            if (done === 1'b1) begin
                lat = c;
                busy_done = busy;
            end
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        rd_idx = 16'd5; #1;
        tests++;
        if (rd_data !== 16'h0000) begin fails++; $display("FAIL reset_rd_oob got %h want 0000", rd_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        logic bs, bd, da;
        load_uniform(16'h0100, 16'h0080, 16'h0040);
        // Out-of-range indices would alias onto element 0 if truncated before checking.
        wr(1'b1, 1'b1, 1'b0, 4, 0, 16'h1234);
        wr(1'b0, 1'b1, 1'b1, 0, 4, 16'h1234);
        run_job(lat, bs, bd, da);
        tests++;
        if (bs !== 1'b1) begin fails++; $display("FAIL basic_busy_after_start got %b want 1", bs); end
        tests++;
        if (lat != 11) begin fails++; $display("FAIL basic_latency got %0d want 11", lat); end
        tests++;
        if (bd !== 1'b0) begin fails++; $display("FAIL basic_busy_in_done got %b want 0", bd); end
        tests++;
        if (da !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", da); end
        for (int i = 0; i < 3; i++) begin
            rd_idx = 16'(i); #1;
            tests++;
            if (rd_data !== 16'h0240) begin fails++; $display("FAIL basic_out%0d got %h want 0240", i, rd_data); end
        end
    endtask

    task automatic test_negative;
        int lat;
        logic bs, bd, da;
        for (int k = 0; k < 4; k++) wr(1'b0, 1'b1, 1'b0, k, 1, 16'hFF00);
        for (int o = 0; o < 3; o++) wr(1'b0, 1'b0, 1'b1, 0, o, 16'h0000);
        run_job(lat, bs, bd, da);
        tests++;
        if (lat != 11) begin fails++; $display("FAIL neg_latency got %0d want 11", lat); end
        rd_idx = 16'd0; #1;
        tests++;
        if (rd_data !== 16'h0200) begin fails++; $display("FAIL neg_out0 got %h want 0200", rd_data); end
        rd_idx = 16'd1; #1;
        tests++;
        if (rd_data !== EXP_NEG) begin fails++; $display("FAIL neg_out1 got %h want %h", rd_data, EXP_NEG); end
        rd_idx = 16'd2; #1;
        tests++;
        if (rd_data !== 16'h0200) begin fails++; $display("FAIL neg_out2 got %h want 0200", rd_data); end
        rd_idx = 16'd5; #1;
        tests++;
        if (rd_data !== 16'h0000) begin fails++; $display("FAIL neg_rd_oob got %h want 0000", rd_data); end
    endtask

    task automatic test_saturation;
        int lat;
        logic bs, bd, da;
        // All three strobes together: act, weight and bias each take the shared value.
        for (int o = 0; o < 3; o++)
            for (int k = 0; k < 4; k++) wr(1'b1, 1'b1, 1'b1, k, o, 16'h7FFF);
        run_job(lat, bs, bd, da);
        for (int i = 0; i < 3; i++) begin
            rd_idx = 16'(i); #1;
            tests++;
            if (rd_data !== 16'h7FFF) begin fails++; $display("FAIL sat_pos_out%0d got %h want 7fff", i, rd_data); end
        end
        for (int o = 0; o < 3; o++)
            for (int k = 0; k < 4; k++) wr(1'b0, 1'b1, 1'b0, k, o, 16'h8001);
        run_job(lat, bs, bd, da);
        tests++;
        if (lat != 11) begin fails++; $display("FAIL sat_latency got %0d want 11", lat); end
        for (int i = 0; i < 3; i++) begin
            rd_idx = 16'(i); #1;
            tests++;
            if (rd_data !== EXP_NEG_SAT) begin fails++; $display("FAIL sat_neg_out%0d got %h want %h", i, rd_data, EXP_NEG_SAT); end
        end
    endtask

    task automatic test_busy_write;
        int c, lat, n_done;
        load_uniform(16'h0100, 16'h0080, 16'h0040);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; n_done = 0;
        for (c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) lat = c;
            end
            if (c == 3) begin
                wr_weight = 1'b1; wr_in_idx = 16'd0; wr_out_idx = 16'd0; wr_data = 16'h1234;
            end
            if (c == 4) wr_weight = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end
        tests++;
        if (lat != 11) begin fails++; $display("FAIL busywr_latency got %0d want 11", lat); end
        tests++;
        if (n_done != 1) begin fails++; $display("FAIL busywr_done_pulses got %0d want 1", n_done); end
        for (int i = 0; i < 3; i++) begin
            rd_idx = 16'(i); #1;
            tests++;
            if (rd_data !== 16'h0240) begin fails++; $display("FAIL busywr_out%0d got %h want 0240", i, rd_data); end
        end
    endtask

    task automatic test_reset_abort;
        int lat, n_done;
        logic bs, bd, da;
        for (int o = 0; o < 3; o++) wr(1'b0, 1'b0, 1'b1, 0, o, 16'h0100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Six edges later the engine is in group 1 MAC.
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
        rst_n = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        tests++;
        if (n_done != 0) begin fails++; $display("FAIL abort_done_pulses got %0d want 0", n_done); end
        rd_idx = 16'd0; #1;
        tests++;
        if (rd_data !== 16'h0300) begin fails++; $display("FAIL abort_out0 got %h want 0300", rd_data); end
        rd_idx = 16'd2; #1;
        tests++;
        if (rd_data !== 16'h0240) begin fails++; $display("FAIL abort_out2_kept got %h want 0240", rd_data); end
        run_job(lat, bs, bd, da);
        tests++;
        if (lat != 11) begin fails++; $display("FAIL abort_restart_latency got %0d want 11", lat); end
        for (int i = 0; i < 3; i++) begin
            rd_idx = 16'(i); #1;
            tests++;
            if (rd_data !== 16'h0300) begin fails++; $display("FAIL abort_restart_out%0d got %h want 0300", i, rd_data); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_act = 1'b0; wr_weight = 1'b0; wr_bias = 1'b0;
        wr_data = '0; wr_in_idx = '0; wr_out_idx = '0;
        start = 1'b0; rd_idx = '0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_busy_write();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
